nios2_pio_in_edge: RTL



---
 rtl/nios2_pio_pkg.sv | 30 +++
 rtl/nios2_pio_debounce.sv | 73 +++++++
 rtl/nios2_pio_in_edge.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nios2_pio_pkg.sv
// rtl/nios2_pio_pkg.sv - shared register offsets and edge constants for the input PIO
//
// Purpose : register word offsets, edge-select encodings and a small helper
//           that picks the captured edge from the rise/fall pair.
// Ports   : none (package).

package nios2_pio_pkg;

  // Avalon word offsets
  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Selects which transition sets a capture bit. Any encoding other than
  // rise/fall captures both directions.
  function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
    case (edge_type)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/nios2_pio_debounce.sv
// rtl/nios2_pio_debounce.sv - single-bit synchroniser plus optional stable-count debouncer
//
// Purpose : brings one asynchronous input into the clk domain and, when
//           DEBOUNCE_CYCLES > 0, only accepts a new level once the synced bit
//           has differed from the accepted value for long enough.
// Ports   :
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   in_bit   in   raw asynchronous input
//   din      out  synchronised (and debounced) value, registered

module nios2_pio_debounce
  import nios2_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic din
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // din is still a register so the latency is the same shape either way
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          din <= 1'b0;
        end else begin
          din <= synced;
        end
      end
    end else begin : g_filter
      localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0]  TERMINAL = CW'(DEBOUNCE_CYCLES);

      logic [CW-1:0] cnt;

      // The counter only runs while the synced bit disagrees with din; any
      // agreement (a glitch ending) throws away the partial count. The value
      // is accepted on the cycle after the count reaches TERMINAL, which is
      // what gives SYNC_STAGES + DEBOUNCE_CYCLES + 1 total latency.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          din <= 1'b0;
        end else if (synced == din) begin
          cnt <= '0;
        end else if (cnt == TERMINAL) begin
          din <= synced;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nios2_pio_in_edge.sv
// rtl/nios2_pio_in_edge.sv - parametrised Avalon-MM input PIO with edge capture and irq
//
// Purpose : samples WIDTH asynchronous inputs, exposes them as a data
//           register, latches selected edges into a write-1-to-clear capture
//           register and drives a masked level interrupt.
// Ports   :
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   Avalon word offset (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  in   slave select, qualifies writes only
//   write_n     in   active-low write strobe
//   writedata   in   write data (bits at WIDTH and above ignored)
//   readdata    out  registered read data, zero-extended
//   in_port     in   raw asynchronous inputs
//   irq         out  OR of (edgecapture & irqmask)

module nios2_pio_in_edge
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] cap_clear;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  // ---------------------------------------------------------------
  // Per-bit input path
  // ---------------------------------------------------------------
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_pio_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[i]),
        .din     (din[i])
      );

      assign edge_set[i] = edge_hit(EDGE_TYPE, din[i] & ~din_d[i], ~din[i] & din_d[i]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_d <= '0;
    end else begin
      din_d <= din;
    end
  end

  // ---------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------
  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  // upper write bits have no destination; folded here so nothing dangles
  assign unused_wdata = ^writedata;

  assign cap_clear = (wr_en && (address == PIO_EDGECAP)) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && (address == PIO_IRQMASK)) begin
      irqmask <= wdata;
    end
  end

  // A new edge in the same cycle as a clear of that bit keeps the bit set,
  // so software never loses an edge that lands during its acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~cap_clear) | edge_set;
    end
  end

  // ---------------------------------------------------------------
  // Read path: registered every cycle regardless of chipselect
  // ---------------------------------------------------------------
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_DATA:    rd_next[WIDTH-1:0] = din;
      PIO_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      PIO_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
      default:     rd_next            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
